// File: rtl/binary_frame_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : binary_frame_ctrl_pkg                                        |
// | Description : Shared state encoding and default values for the binary     |
// |               frame controller and its accumulator.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package binary_frame_ctrl_pkg;

  // Frame controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } bfc_state_e;

  localparam int IMG_W_DEF  = 640;  // binary samples per line
  localparam int IMG_H_DEF  = 480;  // binary lines per frame
  localparam int CW_DEF     = 10;   // coordinate width
  localparam int CNT_W_DEF  = 19;   // foreground counter width
  localparam int THR_W_DEF  = 12;   // grey threshold width

  // Grey window used until software writes a new one
  localparam int THR_LO_DEF = 205;
  localparam int THR_HI_DEF = 255;

endpackage
`default_nettype wire

// File: rtl/binary_frame_ctrl_bbox_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bfc_bbox_acc                                                 |
// | Description : Foreground pixel counter and bounding-box accumulator.       |
// |               Counts qualified foreground pixels (saturating) and tracks   |
// |               min/max column and row of those pixels.                      |
// | Revision    : 1.0 - initial release                                        |
// |----------------------------------------------------------------------------|
// | Ports                                                                      |
// |   clk, rst_n    clock, asynchronous active-low reset                       |
// |   i_clr         clear count, box and has-pixel flag                        |
// |   i_en          pixel strobe qualified by the controller                   |
// |   i_pix         binary pixel, 1 = foreground                               |
// |   i_col, i_row  coordinates of the current pixel                           |
// |   o_count       foreground pixel count                                     |
// |   o_xmin..ymax  bounding box of foreground pixels                          |
// |   o_has_pix     at least one foreground pixel seen since clear             |
// +----------------------------------------------------------------------------+
module bfc_bbox_acc
  import binary_frame_ctrl_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_pix,
  input  logic [CW-1:0]    i_col,
  input  logic [CW-1:0]    i_row,
  output logic [CNT_W-1:0] o_count,
  output logic [CW-1:0]    o_xmin,
  output logic [CW-1:0]    o_xmax,
  output logic [CW-1:0]    o_ymin,
  output logic [CW-1:0]    o_ymax,
  output logic             o_has_pix
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CW-1:0]    xmin_q, xmin_d;
  logic [CW-1:0]    xmax_q, xmax_d;
  logic [CW-1:0]    ymin_q, ymin_d;
  logic [CW-1:0]    ymax_q, ymax_d;
  logic             has_q, has_d;

  always_comb begin
    count_d = count_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    has_d   = has_q;
    if (i_clr) begin
      count_d = '0;
      xmin_d  = '0;
      xmax_d  = '0;
      ymin_d  = '0;
      ymax_d  = '0;
      has_d   = 1'b0;
    end else if (i_en && i_pix) begin
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
      has_d = 1'b1;
      if (!has_q) begin
        // First foreground pixel seeds all four bounds
        xmin_d = i_col;
        xmax_d = i_col;
        ymin_d = i_row;
        ymax_d = i_row;
      end else begin
        if (i_col < xmin_q) xmin_d = i_col;
        if (i_col > xmax_q) xmax_d = i_col;
        if (i_row < ymin_q) ymin_d = i_row;
        if (i_row > ymax_q) ymax_d = i_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      has_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      has_q   <= has_d;
    end
  end

  assign o_count   = count_q;
  assign o_xmin    = xmin_q;
  assign o_xmax    = xmax_q;
  assign o_ymin    = ymin_q;
  assign o_ymax    = ymax_q;
  assign o_has_pix = has_q;

endmodule
`default_nettype wire

// File: rtl/binary_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : binary_frame_ctrl                                            |
// | Description : Frame-level controller for the grey->binary segmentation     |
// |               stage. Shadows the grey threshold window (applied only at    |
// |               frame start), sequences capture windows from iFrame_En and   |
// |               reduces each binary frame to a foreground count and bounding |
// |               box, delivered over a valid/ack handshake.                   |
// | Revision    : 1.0 - initial release                                        |
// |----------------------------------------------------------------------------|
// | Ports                                                                      |
// |   iCLK, iRST_N          clock, asynchronous active-low reset               |
// |   iStart                arm for the next frame (IDLE only)                 |
// |   iCont                 re-arm after ack (1) or return to IDLE (0)         |
// |   iFrame_En             frame window from the sensor path                  |
// |   iBinary, iBVAL        binary pixel and its valid strobe                  |
// |   iCfg_WE/Lo/Hi         threshold write (inclusive grey window)            |
// |   oThr_Lo, oThr_Hi      active window driven to the binariser              |
// |   oCfg_Err              pulse: rejected write (lo > hi)                    |
// |   oCount, oX*/oY*       result of the last captured frame                  |
// |   oBox_Valid            result box holds at least one pixel                |
// |   oRes_Valid, iRes_Ack  result handshake                                   |
// |   oDrop                 frames missed while a result was pending (sat.)    |
// |   oBusy                 armed or capturing                                 |
// +----------------------------------------------------------------------------+
module binary_frame_ctrl
  import binary_frame_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = CW_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int THR_W = THR_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iStart,
  input  logic             iCont,
  input  logic             iFrame_En,
  input  logic             iBinary,
  input  logic             iBVAL,
  input  logic             iCfg_WE,
  input  logic [THR_W-1:0] iCfg_Lo,
  input  logic [THR_W-1:0] iCfg_Hi,
  output logic [THR_W-1:0] oThr_Lo,
  output logic [THR_W-1:0] oThr_Hi,
  output logic             oCfg_Err,
  output logic [CNT_W-1:0] oCount,
  output logic [CW-1:0]    oXmin,
  output logic [CW-1:0]    oXmax,
  output logic [CW-1:0]    oYmin,
  output logic [CW-1:0]    oYmax,
  output logic             oBox_Valid,
  output logic             oRes_Valid,
  input  logic             iRes_Ack,
  output logic [7:0]       oDrop,
  output logic             oBusy
);

  bfc_state_e       state_q, state_d;
  logic             frame_en_q;
  logic [CW-1:0]    col_q, col_d;
  logic [CW-1:0]    row_q, row_d;
  logic             row_done_q, row_done_d;
  logic [THR_W-1:0] pend_lo_q, pend_lo_d;
  logic [THR_W-1:0] pend_hi_q, pend_hi_d;
  logic [THR_W-1:0] thr_lo_q, thr_lo_d;
  logic [THR_W-1:0] thr_hi_q, thr_hi_d;
  logic             cfg_err_q, cfg_err_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic [CW-1:0]    res_xmin_q, res_xmin_d;
  logic [CW-1:0]    res_xmax_q, res_xmax_d;
  logic [CW-1:0]    res_ymin_q, res_ymin_d;
  logic [CW-1:0]    res_ymax_q, res_ymax_d;
  logic             res_box_q, res_box_d;
  logic [7:0]       drop_q, drop_d;

  logic             w_rise;
  logic             w_fall;
  logic             w_acc_clr;
  logic             w_acc_en;
  logic [CNT_W-1:0] w_acc_count;
  logic [CW-1:0]    w_acc_xmin;
  logic [CW-1:0]    w_acc_xmax;
  logic [CW-1:0]    w_acc_ymin;
  logic [CW-1:0]    w_acc_ymax;
  logic             w_acc_has;

  // Edges are taken against the single registered copy of the window
  assign w_rise = iFrame_En & ~frame_en_q;
  assign w_fall = ~iFrame_En & frame_en_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    row_done_d  = row_done_q;
    pend_lo_d   = pend_lo_q;
    pend_hi_d   = pend_hi_q;
    thr_lo_d    = thr_lo_q;
    thr_hi_d    = thr_hi_q;
    res_valid_d = res_valid_q;
    res_count_d = res_count_q;
    res_xmin_d  = res_xmin_q;
    res_xmax_d  = res_xmax_q;
    res_ymin_d  = res_ymin_q;
    res_ymax_d  = res_ymax_q;
    res_box_d   = res_box_q;
    drop_d      = drop_q;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;

    // Threshold writes land in the shadow registers in every state
    cfg_err_d = iCfg_WE && (iCfg_Lo > iCfg_Hi);
    if (iCfg_WE && (iCfg_Lo <= iCfg_Hi)) begin
      pend_lo_d = iCfg_Lo;
      pend_hi_d = iCfg_Hi;
    end

    case (state_q)
      ST_IDLE: begin
        if (iStart) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (w_rise) begin
          state_d    = ST_CAPTURE;
          w_acc_clr  = 1'b1;
          col_d      = '0;
          row_d      = '0;
          row_done_d = 1'b0;
          // Shadow values as of before this cycle, so a coincident write
          // takes effect one frame later
          thr_lo_d   = pend_lo_q;
          thr_hi_d   = pend_hi_q;
        end
      end
      ST_CAPTURE: begin
        if (w_fall) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          res_count_d = w_acc_count;
          res_box_d   = w_acc_has;
          res_xmin_d  = w_acc_has ? w_acc_xmin : '0;
          res_xmax_d  = w_acc_has ? w_acc_xmax : '0;
          res_ymin_d  = w_acc_has ? w_acc_ymin : '0;
          res_ymax_d  = w_acc_has ? w_acc_ymax : '0;
        end else if (iBVAL && !row_done_q) begin
          w_acc_en = 1'b1;
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            // Past the last line everything is discarded until the next frame
            if (row_q == CW'(IMG_H - 1)) row_done_d = 1'b1;
            else                         row_d      = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        if (w_rise && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        if (iRes_Ack) begin
          res_valid_d = 1'b0;
          state_d     = iCont ? ST_ARM : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      frame_en_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      row_done_q  <= 1'b0;
      pend_lo_q   <= THR_W'(THR_LO_DEF);
      pend_hi_q   <= THR_W'(THR_HI_DEF);
      thr_lo_q    <= THR_W'(THR_LO_DEF);
      thr_hi_q    <= THR_W'(THR_HI_DEF);
      cfg_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_xmin_q  <= '0;
      res_xmax_q  <= '0;
      res_ymin_q  <= '0;
      res_ymax_q  <= '0;
      res_box_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      frame_en_q  <= iFrame_En;
      col_q       <= col_d;
      row_q       <= row_d;
      row_done_q  <= row_done_d;
      pend_lo_q   <= pend_lo_d;
      pend_hi_q   <= pend_hi_d;
      thr_lo_q    <= thr_lo_d;
      thr_hi_q    <= thr_hi_d;
      cfg_err_q   <= cfg_err_d;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
      res_xmin_q  <= res_xmin_d;
      res_xmax_q  <= res_xmax_d;
      res_ymin_q  <= res_ymin_d;
      res_ymax_q  <= res_ymax_d;
      res_box_q   <= res_box_d;
      drop_q      <= drop_d;
    end
  end

  bfc_bbox_acc #(
    .CW    (CW),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .i_clr     (w_acc_clr),
    .i_en      (w_acc_en),
    .i_pix     (iBinary),
    .i_col     (col_q),
    .i_row     (row_q),
    .o_count   (w_acc_count),
    .o_xmin    (w_acc_xmin),
    .o_xmax    (w_acc_xmax),
    .o_ymin    (w_acc_ymin),
    .o_ymax    (w_acc_ymax),
    .o_has_pix (w_acc_has)
  );

  assign oThr_Lo    = thr_lo_q;
  assign oThr_Hi    = thr_hi_q;
  assign oCfg_Err   = cfg_err_q;
  assign oCount     = res_count_q;
  assign oXmin      = res_xmin_q;
  assign oXmax      = res_xmax_q;
  assign oYmin      = res_ymin_q;
  assign oYmax      = res_ymax_q;
  assign oBox_Valid = res_box_q;
  assign oRes_Valid = res_valid_q;
  assign oDrop      = drop_q;
  assign oBusy      = (state_q == ST_ARM) || (state_q == ST_CAPTURE);

endmodule
`default_nettype wire

// File: tb/tb_binary_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_binary_frame_ctrl                                         |
// | Description : Self-checking bench for binary_frame_ctrl. A transaction-    |
// |               level model tracks the expected outputs; every cycle the     |
// |               DUT outputs are compared against it.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_binary_frame_ctrl;

  // Reduced image keeps the run short while still covering line wrap and
  // the end-of-frame discard.
  localparam int W     = 200;
  localparam int H     = 150;
  localparam int CW    = 10;
  localparam int CNT_W = 19;
  localparam int THR_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             iRST_N, iStart, iCont, iFrame_En, iBinary, iBVAL, iCfg_WE, iRes_Ack;
  logic [THR_W-1:0] iCfg_Lo, iCfg_Hi;
  logic [THR_W-1:0] oThr_Lo, oThr_Hi;
  logic             oCfg_Err, oBox_Valid, oRes_Valid, oBusy;
  logic [CNT_W-1:0] oCount;
  logic [CW-1:0]    oXmin, oXmax, oYmin, oYmax;
  logic [7:0]       oDrop;

  binary_frame_ctrl #(
    .IMG_W(W), .IMG_H(H), .CW(CW), .CNT_W(CNT_W), .THR_W(THR_W)
  ) dut (
    .iCLK(clk), .iRST_N(iRST_N), .iStart(iStart), .iCont(iCont),
    .iFrame_En(iFrame_En), .iBinary(iBinary), .iBVAL(iBVAL),
    .iCfg_WE(iCfg_WE), .iCfg_Lo(iCfg_Lo), .iCfg_Hi(iCfg_Hi),
    .oThr_Lo(oThr_Lo), .oThr_Hi(oThr_Hi), .oCfg_Err(oCfg_Err),
    .oCount(oCount), .oXmin(oXmin), .oXmax(oXmax), .oYmin(oYmin), .oYmax(oYmax),
    .oBox_Valid(oBox_Valid), .oRes_Valid(oRes_Valid), .iRes_Ack(iRes_Ack),
    .oDrop(oDrop), .oBusy(oBusy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  bit noise    = 0;
  int dens     = 50;

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_ARM, M_CAP, M_DONE} mode_t;
  mode_t m_mode;
  bit    m_fe, m_cfg_err, m_res_valid, m_box_valid;
  int    m_pend_lo, m_pend_hi, m_thr_lo, m_thr_hi;
  int    m_count, m_xmin, m_xmax, m_ymin, m_ymax, m_drop;
  // accumulation of the frame in progress
  int    a_k, a_cnt, a_xmin, a_xmax, a_ymin, a_ymax;
  bit    a_any;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_fe = 0; m_cfg_err = 0; m_res_valid = 0; m_box_valid = 0;
    m_pend_lo = 205; m_pend_hi = 255; m_thr_lo = 205; m_thr_hi = 255;
    m_count = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_drop = 0;
    a_k = 0; a_cnt = 0; a_any = 0; a_xmin = 0; a_xmax = 0; a_ymin = 0; a_ymax = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("thr_lo",    oThr_Lo,    m_thr_lo);
      check("thr_hi",    oThr_Hi,    m_thr_hi);
      check("cfg_err",   oCfg_Err,   m_cfg_err);
      check("res_valid", oRes_Valid, m_res_valid);
      check("count",     oCount,     m_count);
      check("box_valid", oBox_Valid, m_box_valid);
      check("xmin",      oXmin,      m_xmin);
      check("xmax",      oXmax,      m_xmax);
      check("ymin",      oYmin,      m_ymin);
      check("ymax",      oYmax,      m_ymax);
      check("drop",      oDrop,      m_drop);
      check("busy",      oBusy,      (m_mode == M_ARM) || (m_mode == M_CAP));
    end
  end

  // One clock: sample the applied inputs, advance the clock, update the model
  task automatic cycle();
    bit fe, bval, pix, we, st, ack, cont, rst, rise, fall, applied;
    int lo, hi, c, r;
    applied = 0;
    if (noise && m_mode == M_CAP) begin
      applied  = 1;
      iStart   = ($urandom_range(0, 19) == 0);
      iRes_Ack = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) begin
        iCfg_WE = 1;
        iCfg_Lo = THR_W'($urandom_range(0, 4095));
        iCfg_Hi = THR_W'($urandom_range(0, 4095));
      end
    end
    fe = iFrame_En; bval = iBVAL; pix = iBinary; we = iCfg_WE; st = iStart;
    ack = iRes_Ack; cont = iCont; rst = iRST_N; lo = int'(iCfg_Lo); hi = int'(iCfg_Hi);
    @(posedge clk); #1;
    if (applied) begin iStart = 0; iRes_Ack = 0; iCfg_WE = 0; end
    if (!rst) begin model_reset(); return; end
    rise = fe && !m_fe;
    fall = !fe && m_fe;
    m_fe = fe;
    m_cfg_err = we && (lo > hi);
    case (m_mode)
      M_IDLE: if (st) m_mode = M_ARM;
      M_ARM: if (rise) begin
        m_mode = M_CAP; m_thr_lo = m_pend_lo; m_thr_hi = m_pend_hi;
        a_k = 0; a_cnt = 0; a_any = 0;
      end
      M_CAP: begin
        if (fall) begin
          m_mode = M_DONE; m_res_valid = 1; m_count = a_cnt; m_box_valid = a_any;
          m_xmin = a_any ? a_xmin : 0; m_xmax = a_any ? a_xmax : 0;
          m_ymin = a_any ? a_ymin : 0; m_ymax = a_any ? a_ymax : 0;
        end else if (bval) begin
          c = a_k % W; r = a_k / W; a_k++;
          if (r < H && pix) begin
            if (a_cnt < (1 << CNT_W) - 1) a_cnt++;
            if (!a_any) begin a_xmin = c; a_xmax = c; a_ymin = r; a_ymax = r; end
            else begin
              if (c < a_xmin) a_xmin = c;
              if (c > a_xmax) a_xmax = c;
              if (r < a_ymin) a_ymin = r;
              if (r > a_ymax) a_ymax = r;
            end
            a_any = 1;
          end
        end
      end
      M_DONE: begin
        if (rise && m_drop < 255) m_drop++;
        if (ack) begin m_res_valid = 0; m_mode = cont ? M_ARM : M_IDLE; end
      end
      default: ;
    endcase
    if (we && lo <= hi) begin m_pend_lo = lo; m_pend_hi = hi; end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic bit pix_of(int pat, int k);
    int c, r;
    c = k % W; r = k / W;
    case (pat)
      1:       return (c == 17) && (r == 3);
      2:       return (k >= W * H) || (c >= 100 && c <= 199 && r >= 50 && r <= 149);
      3:       return $urandom_range(0, 99) < dens;
      default: return 1'b0;
    endcase
  endfunction

  task automatic strobes(int pat, int n, int gap_pct);
    for (int k = 0; k < n; k++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        iBVAL = 0; iBinary = 1'($urandom_range(0, 1)); cycle();
      end
      iBVAL = 1; iBinary = pix_of(pat, k); cycle();
    end
    iBVAL = 0; iBinary = 0;
  endtask

  task automatic rise_t();  iBVAL = 0; iFrame_En = 1; cycle(); endtask
  task automatic fall_t();  iBVAL = 0; iFrame_En = 0; cycle(); cycle(); endtask
  task automatic start_t(); iStart = 1; cycle(); iStart = 0; endtask
  task automatic ack_t(bit cont);
    iCont = cont; iRes_Ack = 1; cycle(); iRes_Ack = 0; cycle();
  endtask
  task automatic cfg_t(int lo, int hi);
    iCfg_WE = 1; iCfg_Lo = THR_W'(lo); iCfg_Hi = THR_W'(hi); cycle(); iCfg_WE = 0;
  endtask

  initial begin
    iRST_N = 0; iStart = 0; iCont = 0; iFrame_En = 0; iBinary = 0; iBVAL = 0;
    iCfg_WE = 0; iCfg_Lo = '0; iCfg_Hi = '0; iRES_ACK_INIT: iRes_Ack = 0;
    model_reset();
    repeat (3) cycle();
    check("rst_thr_lo", oThr_Lo, 205);
    check("rst_thr_hi", oThr_Hi, 255);
    check("rst_res_valid", oRes_Valid, 0);
    check("rst_busy", oBusy, 0);
    iRST_N = 1; chk_en = 1; cycle();

    // empty frame
    start_t();
    check("busy_armed", oBusy, 1);
    rise_t(); strobes(0, 500, 0); fall_t();
    check("zero_count", oCount, 0);
    check("zero_box_valid", oBox_Valid, 0);
    check("zero_res_valid", oRes_Valid, 1);
    ack_t(1);

    // single pixel at (17,3)
    rise_t(); strobes(1, 4 * W, 10); fall_t();
    check("single_count", oCount, 1);
    check("single_xmin", oXmin, 17);
    check("single_xmax", oXmax, 17);
    check("single_ymin", oYmin, 3);
    check("single_ymax", oYmax, 3);
    check("single_box_valid", oBox_Valid, 1);
    ack_t(1);

    // rectangle, followed by 1000 foreground strobes past the last line
    rise_t(); strobes(2, W * H + 1000, 0); fall_t();
    check("rect_count", oCount, 10000);
    check("rect_xmin", oXmin, 100);
    check("rect_xmax", oXmax, 199);
    check("rect_ymin", oYmin, 50);
    check("rect_ymax", oYmax, 149);
    ack_t(1);
    check("rect_ack_rearm", oBusy, 1);
    check("rect_ack_valid", oRes_Valid, 0);

    // threshold shadowing
    rise_t();
    strobes(0, 20, 0); cfg_t(100, 180);
    check("thr_hold_lo", oThr_Lo, 205);
    check("thr_hold_hi", oThr_Hi, 255);
    strobes(0, 5, 0); cfg_t(200, 10);
    check("cfg_err_pulse", oCfg_Err, 1);
    cycle();
    check("cfg_err_clear", oCfg_Err, 0);
    fall_t(); ack_t(1);
    // write coincident with frame start goes to the following frame
    iCfg_WE = 1; iCfg_Lo = 12'd50; iCfg_Hi = 12'd60; iFrame_En = 1; cycle(); iCfg_WE = 0;
    check("thr_new_lo", oThr_Lo, 100);
    check("thr_new_hi", oThr_Hi, 180);
    strobes(0, 10, 0); fall_t(); ack_t(1);
    rise_t();
    check("thr_late_lo", oThr_Lo, 50);
    check("thr_late_hi", oThr_Hi, 60);
    strobes(1, 4 * W, 0); fall_t();

    // frames arriving while the result is pending
    repeat (3) begin
      iFrame_En = 1; cycle(); cycle(); iFrame_En = 0; cycle(); cycle();
    end
    check("drop3", oDrop, 3);
    check("drop3_count", oCount, 1);
    check("drop3_valid", oRes_Valid, 1);
    iFrame_En = 1; iRes_Ack = 1; iCont = 1; cycle(); iRes_Ack = 0;
    check("drop4", oDrop, 4);
    check("drop4_valid", oRes_Valid, 0);
    cycle(); iFrame_En = 0; cycle(); cycle();
    check("skip_still_armed", oBusy, 1);
    rise_t(); strobes(3, 200, 0); fall_t();
    repeat (260) begin iFrame_En = 1; cycle(); iFrame_En = 0; cycle(); end
    check("drop_sat", oDrop, 255);
    ack_t(0);
    check("ack_to_idle", oBusy, 0);

    // randomized frames with background noise on control inputs
    noise = 1;
    for (int f = 0; f < 8; f++) begin
      if (m_mode == M_IDLE) start_t();
      dens = $urandom_range(0, 100);
      rise_t();
      strobes(3, $urandom_range(50, 1500), $urandom_range(0, 30));
      fall_t();
      repeat ($urandom_range(0, 3)) cycle();
      ack_t(1'($urandom_range(0, 1)));
    end
    noise = 0;

    // asynchronous reset in the middle of a capture
    if (m_mode == M_IDLE) start_t();
    dens = 40;
    rise_t(); strobes(3, 300, 0);
    #2; iRST_N = 0; iFrame_En = 0; model_reset(); #1;
    check("arst_thr_lo", oThr_Lo, 205);
    check("arst_thr_hi", oThr_Hi, 255);
    check("arst_valid", oRes_Valid, 0);
    check("arst_count", oCount, 0);
    check("arst_drop", oDrop, 0);
    check("arst_busy", oBusy, 0);
    repeat (3) cycle();
    iRST_N = 1; cycle();
    start_t(); rise_t(); strobes(1, 4 * W, 0); fall_t();
    check("post_rst_count", oCount, 1);
    ack_t(0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #5ms;
    n_fail++;
    $display("FAIL timeout: got no completion expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
